pll_lock_rst_seq: RTL and testbench

- Parametrised reset manager that sits beside the system PLL. Runs on the PLL reference clock, which is free-running before lock.
- Drives the PLL reset and qualifies its extlock output with a filter. Releases N downstream reset channels in a fixed order, with a programmable gap between releases.
- Retries the PLL automatically when it fails to lock within a timeout. Re-asserts all reset channels when lock is lost.
- Replaces direct use of extlock as a global reset. Consumers resynchronise their rst_out bit into their own clock domain.

---
 rtl/pll_lock_rst_seq_pkg.sv | 25 ++
 rtl/pll_lock_rst_seq_sync_2ff.sv | 31 +++
 rtl/pll_lock_rst_seq.sv | 212 +++++++++++++++++++++
 tb/tb_pll_lock_rst_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_rst_seq_pkg.sv
// pll_lock_rst_seq_pkg
//   Shared definitions for the PLL lock / reset sequencer.
//   - state_e : FSM state codes (also exported on the state_o debug port)
//   - clog2_f : ceil(log2(v)) helper used to size the timers
package pll_lock_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } state_e;

  // ceil(log2(v)); returns 0 for v <= 1
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pll_lock_rst_seq_sync_2ff.sv
// pll_lock_rst_seq_sync_2ff
//   Two-flop synchroniser, reset value 0.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset
//   d_i   : asynchronous input bits
//   q_o   : synchronised output (2 cycles latency)
module pll_lock_rst_seq_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_rst_seq.sv
// pll_lock_rst_seq
//   Reset manager beside the system PLL, clocked by the free-running PLL
//   reference clock. Pulses the PLL reset, filters the synchronised lock
//   flag, then releases N_RST downstream reset channels in order (bit 0
//   first) with RELEASE_GAP cycles between releases. Retries the PLL when
//   lock does not arrive within LOCK_TIMEOUT cycles and re-asserts every
//   channel when lock is lost for LOSS_FILT consecutive cycles.
//
//   Ports
//     refclk        : PLL reference clock (only clock)
//     reset         : asynchronous active-high reset
//     extlock       : PLL lock flag, asynchronous to refclk
//     pll_reset     : active-high reset to the PLL
//     rst_out       : active-high per-channel resets
//     all_ready     : all channels released and FSM in RUN
//     state_o       : current FSM state (debug)
//     lock_loss_cnt : saturating count of declared lock losses
//                     (present only when PLL_LOCK_LOSS_CNT_EN is defined)
//
//   State table
//     state        | meaning
//     PLL_RST   0  | PLL held in reset for PLL_RST_CYC cycles
//     WAIT_LOCK 1  | waiting for lock_s, retry after LOCK_TIMEOUT cycles
//     FILTER    2  | lock_s must stay high LOCK_FILT cycles
//     RELEASE   3  | channels released one per RELEASE_GAP cycles
//     RUN       4  | all channels released, watching for lock loss
module pll_lock_rst_seq
  import pll_lock_rst_seq_pkg::*;
#(
  parameter int N_RST        = 4,
  parameter int PLL_RST_CYC  = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_FILT    = 1024,
  parameter int RELEASE_GAP  = 16,
  parameter int LOSS_FILT    = 4,
  parameter int CNT_W        = 8
) (
  input  logic             refclk,
  input  logic             reset,
  input  logic             extlock,
  output logic             pll_reset,
  output logic [N_RST-1:0] rst_out,
  output logic             all_ready,
  output logic [2:0]       state_o
`ifdef PLL_LOCK_LOSS_CNT_EN
  ,output logic [CNT_W-1:0] lock_loss_cnt
`endif
);

  if (N_RST < 1 || N_RST > 16 || PLL_RST_CYC < 1 || LOCK_TIMEOUT < 2 ||
      LOCK_FILT < 1 || RELEASE_GAP < 1 || LOSS_FILT < 1 || CNT_W < 1) begin : g_param_chk
    $error("pll_lock_rst_seq: parameter out of range");
  end

  // PLL_RST and WAIT_LOCK are never active together, so they share one timer
  localparam int TMR_MAX = (PLL_RST_CYC > LOCK_TIMEOUT) ? PLL_RST_CYC : LOCK_TIMEOUT;
  localparam int TMR_W   = clog2_f(TMR_MAX) + 1;
  localparam int FILT_W  = clog2_f(LOCK_FILT) + 1;
  localparam int GAP_W   = clog2_f(RELEASE_GAP) + 1;
  localparam int LOSS_W  = clog2_f(LOSS_FILT) + 1;
  localparam int IDX_W   = clog2_f(N_RST) + 1;

  state_e             state_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [FILT_W-1:0]  filt_q;
  logic [GAP_W-1:0]   gap_q;
  logic [LOSS_W-1:0]  loss_q;
  logic [IDX_W-1:0]   idx_q;
  logic               pll_reset_q;
  logic [N_RST-1:0]   rst_q;
  logic               all_ready_q;
  logic               lock_s;
  logic               loss_decl;

  pll_lock_rst_seq_sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk_i (refclk),
    .rst_i (reset),
    .d_i   (extlock),
    .q_o   (lock_s)
  );

  // Loss is declared the cycle after the low-lock count reaches LOSS_FILT
  assign loss_decl = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) &&
                     (loss_q == LOSS_W'(LOSS_FILT));

  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_PLL_RST;
      tmr_q       <= '0;
      filt_q      <= '0;
      gap_q       <= '0;
      loss_q      <= '0;
      idx_q       <= '0;
      pll_reset_q <= 1'b1;
      rst_q       <= '1;
      all_ready_q <= 1'b0;
    end else if (loss_decl) begin
      // takes priority over any channel release due in the same cycle
      state_q     <= ST_PLL_RST;
      tmr_q       <= '0;
      filt_q      <= '0;
      gap_q       <= '0;
      loss_q      <= '0;
      idx_q       <= '0;
      pll_reset_q <= 1'b1;
      rst_q       <= '1;
      all_ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (tmr_q == TMR_W'(PLL_RST_CYC - 1)) begin
            state_q     <= ST_WAIT_LOCK;
            tmr_q       <= '0;
            pll_reset_q <= 1'b0;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          if (lock_s) begin
            // the cycle that sees lock counts as the first filter cycle
            tmr_q <= '0;
            if (LOCK_FILT == 1) begin
              state_q <= ST_RELEASE;
              gap_q   <= '0;
              idx_q   <= '0;
              loss_q  <= '0;
            end else begin
              state_q <= ST_FILTER;
              filt_q  <= FILT_W'(1);
            end
          end else if (tmr_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
            state_q     <= ST_PLL_RST;
            tmr_q       <= '0;
            pll_reset_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end

        ST_FILTER: begin
          if (!lock_s) begin
            state_q <= ST_WAIT_LOCK;
            tmr_q   <= '0;
            filt_q  <= '0;
          end else if (filt_q == FILT_W'(LOCK_FILT - 1)) begin
            state_q <= ST_RELEASE;
            filt_q  <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            loss_q  <= '0;
          end else begin
            filt_q <= filt_q + 1'b1;
          end
        end

        ST_RELEASE: begin
          loss_q <= lock_s ? '0 : loss_q + 1'b1;
          if (gap_q == GAP_W'(RELEASE_GAP - 1)) begin
            gap_q <= '0;
            idx_q <= idx_q + 1'b1;
            for (int k = 0; k < N_RST; k++) begin
              if (idx_q == IDX_W'(k)) rst_q[k] <= 1'b0;
            end
            if (idx_q == IDX_W'(N_RST - 1)) state_q <= ST_RUN;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end

        ST_RUN: begin
          loss_q      <= lock_s ? '0 : loss_q + 1'b1;
          all_ready_q <= 1'b1;
        end

        default: begin
          state_q     <= ST_PLL_RST;
          tmr_q       <= '0;
          filt_q      <= '0;
          gap_q       <= '0;
          loss_q      <= '0;
          idx_q       <= '0;
          pll_reset_q <= 1'b1;
          rst_q       <= '1;
          all_ready_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [CNT_W-1:0] loss_cnt_q;

  // timeout retries never pass through loss_decl, so they are not counted
  always_ff @(posedge refclk or posedge reset) begin
    if (reset) begin
      loss_cnt_q <= '0;
    end else if (loss_decl && (loss_cnt_q != '1)) begin
      loss_cnt_q <= loss_cnt_q + 1'b1;
    end
  end

  assign lock_loss_cnt = loss_cnt_q;
`endif

  assign pll_reset = pll_reset_q;
  assign rst_out   = rst_q;
  assign all_ready = all_ready_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
module tb_pll_lock_rst_seq;

  localparam int N_RST        = 3;
  localparam int PLL_RST_CYC  = 4;
  localparam int LOCK_TIMEOUT = 32;
  localparam int LOCK_FILT    = 8;
  localparam int RELEASE_GAP  = 3;
  localparam int LOSS_FILT    = 2;
  localparam int CNT_W        = 8;

  logic             refclk = 1'b0;
  logic             reset;
  logic             extlock;
  logic             pll_reset;
  logic [N_RST-1:0] rst_out;
  logic             all_ready;
  logic [2:0]       state_o;
`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [CNT_W-1:0] lock_loss_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pll_lock_rst_seq #(
    .N_RST        (N_RST),
    .PLL_RST_CYC  (PLL_RST_CYC),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .LOCK_FILT    (LOCK_FILT),
    .RELEASE_GAP  (RELEASE_GAP),
    .LOSS_FILT    (LOSS_FILT),
    .CNT_W        (CNT_W)
  ) dut (
    .refclk    (refclk),
    .reset     (reset),
    .extlock   (extlock),
    .pll_reset (pll_reset),
    .rst_out   (rst_out),
    .all_ready (all_ready),
    .state_o   (state_o)
`ifdef PLL_LOCK_LOSS_CNT_EN
    ,.lock_loss_cnt (lock_loss_cnt)
`endif
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, t0, t1, t2, ta, ts, tr, tf, tw, chg, bad, prev, nr, nf, wcnt;
    int rises [3];
    int falls [3];

    // ---------------- reset state ----------------
    reset   = 1'b1;
    extlock = 1'b0;
    tick(); tick();
    chk("rst_pll_reset", pll_reset, 1);
    chk("rst_rst_out",   rst_out,   3'b111);
    chk("rst_all_ready", all_ready, 0);
    chk("rst_state",     state_o,   0);
`ifdef PLL_LOCK_LOSS_CNT_EN
    chk("rst_loss_cnt",  lock_loss_cnt, 0);
`endif

    // ---------------- 1: normal lock and release ----------------
    reset = 1'b0;
    hi = 0;
    for (int j = 1; j <= 3; j++) begin
      tick();
      if (pll_reset) hi++;
    end
    chk("t1_pll_rst_width", hi, 3);
    tick();
    chk("t1_pll_rst_fall", pll_reset, 0);
    chk("t1_wait_state",   state_o,   1);
    for (int j = 1; j <= 20; j++) tick();
    extlock = 1'b1;
    t0 = -1; t1 = -1; t2 = -1; ta = -1; ts = -1; hi = 0;
    for (int j = 1; j <= 25; j++) begin
      tick();
      if (state_o == 3'd3 && ts < 0) ts = j;
      if (!rst_out[0] && t0 < 0) t0 = j;
      if (!rst_out[1] && t1 < 0) t1 = j;
      if (!rst_out[2] && t2 < 0) t2 = j;
      if (all_ready && ta < 0) ta = j;
      if (pll_reset) hi++;
    end
    chk("t1_release_entry", ts, 10);
    chk("t1_rst0_fall",     t0, 13);
    chk("t1_rst1_fall",     t1, 16);
    chk("t1_rst2_fall",     t2, 19);
    chk("t1_all_ready",     ta, 20);
    chk("t1_pll_rst_low",   hi, 0);
    chk("t1_run_state",     state_o, 4);

    // ---------------- 3: lock loss filtering ----------------
    extlock = 1'b0;
    tick();
    extlock = 1'b1;
    chg = 0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      if (rst_out != 3'b000 || !all_ready || pll_reset) chg++;
    end
    chk("t3_glitch_ignored", chg, 0);
    extlock = 1'b0;
    tr = -1; ta = -1; ts = -1; hi = -1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (j == 3) extlock = 1'b1;
      if (rst_out == 3'b111 && tr < 0) tr = j;
      if (!all_ready && ta < 0) ta = j;
      if (state_o == 3'd0 && ts < 0) ts = j;
      if (pll_reset && hi < 0) hi = j;
    end
    chk("t3_loss_rst_out",   tr, 5);
    chk("t3_loss_all_ready", ta, 5);
    chk("t3_loss_state",     ts, 5);
    chk("t3_loss_pll_reset", hi, 5);
`ifdef PLL_LOCK_LOSS_CNT_EN
    chk("t3_loss_cnt", lock_loss_cnt, 1);
`endif

    // ---------------- 2: timeout retries ----------------
    reset   = 1'b1;
    extlock = 1'b0;
    tick();
    reset = 1'b0;
    prev = 1; nr = 0; nf = 0; bad = 0;
    for (int i = 0; i < 3; i++) begin
      rises[i] = -1;
      falls[i] = -1;
    end
    for (int j = 1; j <= 110; j++) begin
      tick();
      if (pll_reset && prev == 0 && nr < 3) begin rises[nr] = j; nr++; end
      if (!pll_reset && prev == 1 && nf < 3) begin falls[nf] = j; nf++; end
      prev = pll_reset ? 1 : 0;
      if (rst_out != 3'b111 || all_ready) bad++;
    end
    chk("t2_fall0", falls[0], 4);
    chk("t2_rise0", rises[0], 36);
    chk("t2_fall1", falls[1], 40);
    chk("t2_rise1", rises[1], 72);
    chk("t2_fall2", falls[2], 76);
    chk("t2_rise2", rises[2], 108);
    chk("t2_rst_held", bad, 0);

    // ---------------- 4: lock drop during FILTER ----------------
    reset   = 1'b1;
    extlock = 1'b0;
    tick();
    reset = 1'b0;
    for (int j = 1; j <= 4; j++) tick();
    chk("t4_wait_state", state_o, 1);
    extlock = 1'b1;
    tf = -1; tw = -1; t0 = -1;
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (j == 5) extlock = 1'b0;
      if (j == 6) extlock = 1'b1;
      if (state_o == 3'd2 && tf < 0) tf = j;
      if (tf >= 0 && state_o == 3'd1 && tw < 0) tw = j;
      if (!rst_out[0] && t0 < 0) t0 = j;
    end
    chk("t4_filter_entry", tf, 3);
    chk("t4_back_to_wait", tw, 8);
    chk("t4_rst0_fall",    t0, 19);

    // ---------------- 5: async reset during RELEASE ----------------
    chk("t5_pre_state",   state_o, 3);
    chk("t5_pre_rst_out", rst_out, 3'b110);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_pll_reset", pll_reset, 1);
    chk("t5_rst_out",   rst_out,   3'b111);
    chk("t5_all_ready", all_ready, 0);
    chk("t5_state",     state_o,   0);

`ifdef PLL_LOCK_LOSS_CNT_EN
    // ---------------- 6: loss counter saturation ----------------
    extlock = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 300; k++) begin
      wcnt = 0;
      while (state_o != 3'd3 && wcnt < 60) begin
        tick();
        wcnt++;
      end
      if (state_o != 3'd3) begin
        chk("t6_reach_release", state_o, 3);
        break;
      end
      extlock = 1'b0;
      for (int j = 1; j <= 4; j++) tick();
      extlock = 1'b1;
      tick(); tick();
      if (k == 0)   chk("t6_cnt_first", lock_loss_cnt, 1);
      if (k == 254) chk("t6_cnt_255",   lock_loss_cnt, 255);
    end
    chk("t6_cnt_saturated", lock_loss_cnt, 255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
